// File: rtl/bcd_split_if.sv
// Valid/ready bundle between an arithmetic result source and the BCD splitter.
// The master drives operands and accepts results; the slave is the splitter.
interface bcd_split_if #(
    parameter int W = 16,
    parameter int D = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     v;
    logic             out_valid;
    logic             out_ready;
    logic [4*D-1:0]   digits;
    logic             neg;
    logic             ovf;

    modport master (
        output in_valid, v, out_ready,
        input  in_ready, out_valid, digits, neg, ovf
    );

    modport slave (
        input  in_valid, v, out_ready,
        output in_ready, out_valid, digits, neg, ovf
    );
endinterface

// File: rtl/bcd_split_seq.sv
// Sequential binary-to-BCD splitter: one double-dabble step per clock, with
// sign extraction, sticky overflow and valid/ready on both sides.
module bcd_split_seq #(
    parameter int W      = 16,
    parameter int D      = 5,
    parameter bit SIGNED = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    bcd_split_if.slave bus
);
    localparam int SRW = 4 * D + W;
    localparam int CW  = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

    state_e         state_q, state_d;
    logic [SRW-1:0] sr_q, sr_d, sr_adj;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           neg_q, neg_d;
    logic           ovf_q, ovf_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic           neg_in;
    logic [W-1:0]   mag_in;

    // Upper 4*D bits of the shift register hold the BCD digits, lower W bits the magnitude.
    always_comb begin
        neg_in = SIGNED && bus.v[W-1];
        mag_in = neg_in ? -bus.v : bus.v;
        sr_adj = sr_q;
        for (int i = 0; i < D; i++) begin
            if (sr_q[W+4*i +: 4] >= 4'd5)
                sr_adj[W+4*i +: 4] = sr_q[W+4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        ovf_d       = ovf_q;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (bus.in_valid && in_ready_q) begin
                    neg_d      = neg_in;
                    sr_d       = {{(4*D){1'b0}}, mag_in};
                    ovf_d      = 1'b0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = CONV;
                end
            end
            CONV: begin
                sr_d  = {sr_adj[SRW-2:0], 1'b0};
                ovf_d = ovf_q | sr_adj[SRW-1];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                out_valid_d = 1'b1;
                // Consuming a result returns to IDLE; a waiting operand is taken next edge.
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.digits    = sr_q[SRW-1:W];
    assign bus.neg       = neg_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_bcd_split_seq.sv
// Directed and randomized bench for bcd_split_seq; expected results come from
// a decimal-arithmetic reference model and fixed constants.
module tb_bcd_split_seq;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    bcd_split_if #(.W(16), .D(5)) bus_a ();
    bcd_split_if #(.W(16), .D(3)) bus_b ();

    bcd_split_seq #(.W(16), .D(5), .SIGNED(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    bcd_split_seq #(.W(16), .D(3), .SIGNED(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {digits, neg, ovf} from plain decimal arithmetic on |v|.
    function automatic logic [21:0] ref_split(input logic [15:0] val, input bit sgn, input int nd);
        longint      m;
        longint      lim;
        logic        ng;
        logic        ov;
        logic [19:0] dg;
        ng  = sgn && val[15];
        m   = ng ? (longint'(65536) - longint'(val)) : longint'(val);
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        ov  = (m >= lim);
        m   = m % lim;
        dg  = '0;
        for (int i = 0; i < nd; i++) begin
            dg[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return {dg, ng, ov};
    endfunction

    task automatic run_a(input string tag, input logic [15:0] val, input logic [21:0] exp);
        check({tag, " ready"}, 32'(bus_a.in_ready), 32'd1);
        bus_a.in_valid = 1'b1;
        bus_a.v        = val;
        tick();
        bus_a.in_valid = 1'b0;
        check({tag, " busy"}, 32'(bus_a.in_ready), 32'd0);
        repeat (15) tick();
        check({tag, " early"}, 32'(bus_a.out_valid), 32'd0);
        tick();
        check({tag, " valid"}, 32'(bus_a.out_valid), 32'd1);
        check({tag, " result"}, 32'({bus_a.digits, bus_a.neg, bus_a.ovf}), 32'(exp));
    endtask

    task automatic release_a(input string tag);
        bus_a.out_ready = 1'b1;
        tick();
        bus_a.out_ready = 1'b0;
        check({tag, " drained"}, 32'(bus_a.out_valid), 32'd0);
        check({tag, " idle"}, 32'(bus_a.in_ready), 32'd1);
    endtask

    task automatic run_b(input string tag, input logic [15:0] val, input logic [13:0] exp);
        check({tag, " ready"}, 32'(bus_b.in_ready), 32'd1);
        bus_b.in_valid = 1'b1;
        bus_b.v        = val;
        tick();
        bus_b.in_valid = 1'b0;
        repeat (16) tick();
        check({tag, " valid"}, 32'(bus_b.out_valid), 32'd1);
        check({tag, " result"}, 32'({bus_b.digits, bus_b.neg, bus_b.ovf}), 32'(exp));
        bus_b.out_ready = 1'b1;
        tick();
        bus_b.out_ready = 1'b0;
    endtask

    initial begin
        logic [21:0] exp_q[$];
        logic [21:0] exp_r;
        logic [21:0] pre_res;
        logic [15:0] cur;
        logic        pre_ir;
        logic        pre_ov;
        bit          presenting;
        int          sent;
        int          got;
        int          cycles;
        int          seen;

        rst             = 1'b1;
        bus_a.in_valid  = 1'b0;
        bus_a.v         = '0;
        bus_a.out_ready = 1'b0;
        bus_b.in_valid  = 1'b0;
        bus_b.v         = '0;
        bus_b.out_ready = 1'b0;
        tick();
        check("reset in_ready", 32'(bus_a.in_ready), 32'd0);
        check("reset out_valid", 32'(bus_a.out_valid), 32'd0);
        check("reset digits", 32'(bus_a.digits), 32'd0);
        check("reset neg", 32'(bus_a.neg), 32'd0);
        check("reset ovf", 32'(bus_a.ovf), 32'd0);
        rst = 1'b0;
        tick();
        check("post-reset in_ready", 32'(bus_a.in_ready), 32'd1);

        run_a("v9801", 16'd9801, {20'h09801, 1'b0, 1'b0});
        release_a("v9801");
        run_a("vm1", 16'hFFFF, {20'h00001, 1'b1, 1'b0});
        release_a("vm1");
        run_a("vmin", 16'h8000, {20'h32768, 1'b1, 1'b0});
        release_a("vmin");
        run_a("vzero", 16'd0, {20'h00000, 1'b0, 1'b0});
        release_a("vzero");

        // Backpressure with an ignored operand pulse while the result is pending.
        run_a("v2601", 16'd2601, {20'h02601, 1'b0, 1'b0});
        for (int i = 0; i < 5; i++) begin
            bus_a.in_valid = (i == 2);
            bus_a.v        = (i == 2) ? 16'd7 : 16'd0;
            tick();
            check("bp out_valid", 32'(bus_a.out_valid), 32'd1);
            check("bp result", 32'({bus_a.digits, bus_a.neg, bus_a.ovf}), 32'({20'h02601, 1'b0, 1'b0}));
            check("bp in_ready", 32'(bus_a.in_ready), 32'd0);
        end
        bus_a.in_valid = 1'b0;
        release_a("v2601");
        run_a("v7", 16'd7, {20'h00007, 1'b0, 1'b0});

        // Operand offered in the same cycle the result is consumed waits one edge.
        bus_a.in_valid  = 1'b1;
        bus_a.v         = 16'd5;
        bus_a.out_ready = 1'b1;
        tick();
        bus_a.out_ready = 1'b0;
        check("simul out_valid", 32'(bus_a.out_valid), 32'd0);
        check("simul not taken", 32'(bus_a.in_ready), 32'd1);
        tick();
        bus_a.in_valid = 1'b0;
        check("simul taken", 32'(bus_a.in_ready), 32'd0);
        repeat (15) tick();
        check("simul early", 32'(bus_a.out_valid), 32'd0);
        tick();
        check("simul valid", 32'(bus_a.out_valid), 32'd1);
        check("simul result", 32'({bus_a.digits, bus_a.neg, bus_a.ovf}), 32'({20'h00005, 1'b0, 1'b0}));
        release_a("simul");

        // Reset in the middle of a conversion.
        bus_a.in_valid = 1'b1;
        bus_a.v        = 16'd1234;
        tick();
        bus_a.in_valid = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        check("abort in_ready", 32'(bus_a.in_ready), 32'd0);
        check("abort out_valid", 32'(bus_a.out_valid), 32'd0);
        check("abort digits", 32'(bus_a.digits), 32'd0);
        check("abort neg", 32'(bus_a.neg), 32'd0);
        check("abort ovf", 32'(bus_a.ovf), 32'd0);
        rst = 1'b0;
        tick();
        check("abort in_ready back", 32'(bus_a.in_ready), 32'd1);
        seen = 0;
        repeat (40) begin
            tick();
            if (bus_a.out_valid) seen++;
        end
        check("abort no result", 32'(seen), 32'd0);

        // Narrow unsigned instance: overflow and the largest fitting value.
        run_b("b2500", 16'd2500, {12'h500, 1'b0, 1'b1});
        run_b("bffff", 16'hFFFF, {12'h535, 1'b0, 1'b1});
        run_b("b999", 16'd999, {12'h999, 1'b0, 1'b0});
        run_b("b1000", 16'd1000, {12'h000, 1'b0, 1'b1});

        // Random back-to-back stream with random consumer stalls.
        presenting = 1'b0;
        sent       = 0;
        got        = 0;
        cycles     = 0;
        cur        = '0;
        while ((sent < 200 || got < sent) && cycles < 20000) begin
            if (!presenting && sent < 200) begin
                cur = 16'($urandom);
                case ($urandom_range(0, 9))
                    0: cur = 16'h0000;
                    1: cur = 16'h8000;
                    2: cur = 16'hFFFF;
                    3: cur = 16'h7FFF;
                    default: ;
                endcase
                presenting = 1'b1;
            end
            bus_a.in_valid  = presenting;
            bus_a.v         = cur;
            bus_a.out_ready = 1'($urandom_range(0, 1));
            pre_ir  = bus_a.in_ready;
            pre_ov  = bus_a.out_valid;
            pre_res = {bus_a.digits, bus_a.neg, bus_a.ovf};
            tick();
            cycles++;
            if (presenting && pre_ir) begin
                exp_q.push_back(ref_split(cur, 1'b1, 5));
                sent++;
                presenting = 1'b0;
            end
            if (pre_ov && bus_a.out_ready) begin
                got++;
                check("stream expected pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    exp_r = exp_q.pop_front();
                    check("stream result", 32'(pre_res), 32'(exp_r));
                end
            end
        end
        bus_a.in_valid  = 1'b0;
        bus_a.out_ready = 1'b0;
        check("stream within budget", 32'(cycles < 20000), 32'd1);
        check("stream results", 32'(got), 32'd200);
        check("stream leftover", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bcd_split_seq.md
# bcd_split_seq

Sequential, parametrised binary-to-BCD splitter for the calculator datapath. It takes a W-bit operand, for example a `calc_mul` product or a `calc_div` quotient. It returns D packed BCD digits plus a sign flag for the display stage, computed by iterative shift-and-add-3 (double dabble) at one bit per clock. A valid/ready handshake on both sides lets it sit between registered arithmetic and the digit drivers, and it flags values that do not fit in D digits.

## Interface
- W, 16: input operand width in bits, W ≥ 2.
- D, 5: number of BCD output digits, D ≥ 1.
- SIGNED, 1: when 1, v is two's complement; when 0, v is unsigned.

- clk  in  1  system clock, all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  v is presented.
- in_ready  out  1  block can accept an operand.
- v  in  W  operand to convert.
- out_valid  out  1  result on digits/neg/ovf is valid.
- out_ready  in  1  consumer accepts the result.
- digits  out  4*D  packed BCD; digit 0 (ones) is in [3:0], digit D-1 is in the top nibble.
- neg  out  1  operand was negative.
- ovf  out  1  magnitude > 10^D − 1; digits hold the magnitude mod 10^D.

## Operation
- The FSM has three states: IDLE, CONV and DONE.
- **IDLE**
  - in_ready = 1 and out_valid = 0.
  - On in_valid & in_ready, register the following, then go to CONV:
    - neg = SIGNED & v[W-1].
    - mag = neg ? −v : v, computed as a W-bit unsigned value. For v = −2^(W-1), mag = 2^(W-1), which is representable unsigned.
    - Clear the BCD shift register, clear ovf, and set the bit counter to 0.
- **CONV**
  - Each cycle performs one step, in this order:
    1. Every BCD nibble ≥ 5 gets +3. All nibbles are adjusted in parallel, combinationally.
    2. {bcd, mag} shifts left by 1.
  - The bit shifted out of the top nibble ORs into ovf, which is sticky.
  - The counter increments each cycle. After W steps, go to DONE.
  - in_ready = 0 throughout CONV.
- **DONE**
  - out_valid = 1, and digits/neg/ovf are held stable.
  - On out_ready, go to IDLE.
  - in_ready = 0 in DONE; no new operand is accepted while a result is pending.
- **Width rules**
  - The counter width is clog2(W+1).
  - The shift register is 4*D + W bits.
  - No nibble ever exceeds 9 after a step.
- **Zero:** all digits are 0, neg = 0, ovf = 0. Negative zero cannot occur.
- **SIGNED = 0:** neg is constant 0 and v[W-1] is treated as magnitude.
- digits/neg/ovf are defined only while out_valid = 1. During CONV they may expose intermediate shift contents.

## Timing
- **Reset values:** in_ready = 0 during the reset cycle, then 1 from the first cycle after rst deasserts. out_valid = 0, digits = 0, neg = 0, ovf = 0. The state is IDLE.
- **Latency:** the accept edge is edge 0. out_valid is high from edge W onward, so the result appears W cycles after acceptance.
- **Throughput:** one conversion per W + 2 cycles when out_ready is held high. The sequence is accept, then W CONV cycles, then 1 DONE cycle, then back to IDLE.
- **Backpressure:** out_valid stays high, with outputs unchanged, for as long as out_ready = 0.
- **Simultaneous in_valid and out_ready in DONE:** the result is consumed and the new operand is not accepted in that cycle. It is accepted at the following IDLE edge if in_valid is still high.
- **in_valid during CONV or DONE:** ignored, and v is not sampled.
- **Reset mid-conversion or while DONE:**
  - The in-flight operand and result are discarded.
  - All outputs return to their reset values on the edge where rst is high.
  - No out_valid pulse is produced for the aborted operand.
- rst has priority over every handshake.

## Test plan
- W=16, D=5, SIGNED=1, v=9801 (99×99 product) → exactly 16 cycles after accept: digits = 0_9_8_0_1, neg = 0, ovf = 0.
- v=16'hFFFF (−1) → digits = 0_0_0_0_1, neg = 1. Then v=16'h8000 → digits = 3_2_7_6_8, neg = 1, ovf = 0.
- v=0 → digits = 0, neg = 0, ovf = 0, with out_valid at cycle 16. In a second instance with W=16, D=3, SIGNED=0, v=2500 → digits = 5_0_0, ovf = 1.
- Backpressure, v=2601 (51×51): hold out_ready low for 5 cycles after out_valid rises. out_valid and digits 0_2_6_0_1 must stay stable, in_ready = 0, and an in_valid pulse with v=7 is ignored. Raise out_ready: the next accept happens 1 cycle later, and the result 0_0_0_0_7 appears only if v=7 is re-presented.
- Reset mid-conversion: accept v=1234, assert rst for 1 cycle at cycle 8 → all outputs are reset values on the next edge, no out_valid ever appears for 1234, and in_ready = 1 the cycle after rst deasserts.
- Back-to-back stream of 200 random signed operands with random out_ready → each (digits, neg, ovf) matches the reference decimal split of |v|, the results arrive in order, and no result is dropped or duplicated.
